// File: rtl/fifo_drain.sv
// fifo_drain: drains a dual-clock FIFO read port into a valid/ready stream.
// The FIFO delivers read data one rd_clk after the read strobe, so a 2-entry
// skid buffer (head, tail) absorbs the word still in flight when the
// downstream stalls. Reads are issued only while buffered plus in-flight
// words would stay below two, so nothing is ever dropped.
// Optional feature: define FIFO_DRAIN_CNT_EN to add the sample_cnt port and
// a 16-bit wrapping count of accepted samples.
`timescale 1ns/1ps
module fifo_drain #(
    parameter int DWIDTH = 16
) (
    input  logic              rd_clk,
    input  logic              areset_n,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_q,
    output logic              fifo_read,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
`ifdef FIFO_DRAIN_CNT_EN
    output logic [15:0]       sample_cnt,
`endif
    input  logic              m_ready
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [DWIDTH-1:0] r_head;
    logic [DWIDTH-1:0] r_tail;

    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_head_cap;
    logic              w_tail_cap;
    logic              w_shift;
    logic [1:0]        w_occ_nxt;

    // w_level never underflows: a pop implies at least one buffered word.
    assign w_pop      = (r_occ != EMPTY) & m_ready;
    assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_read  = areset_n & ~fifo_empty & (w_level < 3'd2);

    // The arriving word lands in head when the buffer drains this cycle,
    // otherwise it queues behind head. In TWO no word can be in flight.
    assign w_head_cap = r_inflight & ((r_occ == EMPTY) | ((r_occ == ONE) & w_pop));
    assign w_tail_cap = r_inflight & ~w_head_cap;
    assign w_shift    = w_pop & (r_occ == TWO);

    assign m_valid    = (r_occ != EMPTY);
    assign m_data     = r_head;

    // Occupancy next-state from capture and pop.
    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            EMPTY: begin
                if (r_inflight) w_occ_nxt = ONE;
            end
            ONE: begin
                if (r_inflight && !w_pop)      w_occ_nxt = TWO;
                else if (!r_inflight && w_pop) w_occ_nxt = EMPTY;
            end
            TWO: begin
                if (w_pop) w_occ_nxt = ONE;
            end
            default: w_occ_nxt = EMPTY;
        endcase
    end

    // Control state: occupancy and the read-data-pending flag.
    always_ff @(posedge rd_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_occ      <= EMPTY;
            r_inflight <= 1'b0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= fifo_read;
        end
    end

    // Head register drives m_data, so it is cleared on reset.
    always_ff @(posedge rd_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_head <= '0;
        end else if (w_head_cap) begin
            r_head <= fifo_q;
        end else if (w_shift) begin
            r_head <= r_tail;
        end
    end

    // Tail register is only read when occupancy says it holds a word.
    always_ff @(posedge rd_clk) begin
        if (w_tail_cap) begin
            r_tail <= fifo_q;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] r_sample_cnt;

    // Accepted-sample counter, wraps naturally at 16 bits.
    always_ff @(posedge rd_clk or negedge areset_n) begin
        if (!areset_n) begin
            r_sample_cnt <= 16'h0000;
        end else if (w_pop) begin
            r_sample_cnt <= r_sample_cnt + 16'h0001;
        end
    end

    assign sample_cnt = r_sample_cnt;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: bench for fifo_drain with a behavioural FIFO read port and
// a scoreboard of words handed to the DUT, compared as the stream accepts.
// Inputs change at posedge+2; outputs are sampled at negedge.
`timescale 1ns/1ps
module tb_fifo_drain;

    logic        rd_clk     = 1'b0;
    logic        areset_n   = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_q     = 16'h0000;
    logic        m_ready    = 1'b0;
    logic        fifo_read;
    logic [15:0] m_data;
    logic        m_valid;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] sample_cnt;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] mem[$];
    logic [15:0] exp_q[$];
    logic        rd_n        = 1'b0;
    int          outstanding = 0;

    fifo_drain #(.DWIDTH(16)) dut (
        .rd_clk     (rd_clk),
        .areset_n   (areset_n),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_read  (fifo_read),
        .m_data     (m_data),
        .m_valid    (m_valid),
`ifdef FIFO_DRAIN_CNT_EN
        .sample_cnt (sample_cnt),
`endif
        .m_ready    (m_ready)
    );

    always #5 rd_clk = ~rd_clk;

    // Scoreboard monitor and running invariants, sampled mid-cycle.
    always @(negedge rd_clk) begin
        logic [15:0] e;
        if (!areset_n) begin
            rd_n        = 1'b0;
            outstanding = 0;
        end else begin
            rd_n = fifo_read;
            if (fifo_read) begin
                n_checks++;
                if (fifo_empty) $display("FAIL underflow_read: fifo_read=1 while fifo_empty=1 at %0t", $time);
                else n_pass++;
            end
            if (m_valid && m_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_extra: got %h with no expected word", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) $display("FAIL sb_data: got %h expected %h", m_data, e);
                    else n_pass++;
                end
            end
            outstanding = outstanding + (fifo_read ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            n_checks++;
            if (outstanding > 2 || outstanding < 0)
                $display("FAIL level: buffered+inflight=%0d allowed 0..2", outstanding);
            else n_pass++;
        end
    end

    // FIFO read port model: data appears one clock after the read strobe.
    always @(posedge rd_clk) begin
        #1;
        if (rd_n) begin
            if (mem.size() > 0) begin
                fifo_q = mem.pop_front();
                exp_q.push_back(fifo_q);
            end
            fifo_empty = (mem.size() == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic sample();
        @(negedge rd_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic test_reset();
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        repeat (3) tick();
        sample();
        n_checks++;
        if (fifo_read !== 1'b0) $display("FAIL rst_read: got %b expected 0", fifo_read); else n_pass++;
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", m_valid); else n_pass++;
        n_checks++;
        if (m_data !== 16'h0000) $display("FAIL rst_data: got %h expected 0000", m_data); else n_pass++;
`ifdef FIFO_DRAIN_CNT_EN
        n_checks++;
        if (sample_cnt !== 16'h0000) $display("FAIL rst_cnt: got %h expected 0000", sample_cnt); else n_pass++;
`endif
        fifo_empty = 1'b1;
        tick();
        areset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample();
            n_checks++;
            if (fifo_read !== 1'b0 || m_valid !== 1'b0)
                $display("FAIL idle_empty: cycle %0d read=%b valid=%b expected 0/0", i, fifo_read, m_valid);
            else n_pass++;
        end
    endtask

    task automatic test_stream();
        int nrd = 0, first_rd = -1, last_rd = -1;
        int nd = 0, first_d = -1, last_d = -1;
        tick();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(16'(i));
        for (int c = 0; c < 20; c++) begin
            sample();
            if (fifo_read) begin
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                nrd++;
            end
            if (m_valid && m_ready) begin
                n_checks++;
                if (m_data !== 16'(nd + 1)) $display("FAIL stream_data: got %h expected %h", m_data, 16'(nd + 1));
                else n_pass++;
                if (first_d < 0) first_d = c;
                last_d = c;
                nd++;
            end
        end
        n_checks++;
        if (nrd != 8 || first_rd != 0 || last_rd != 7)
            $display("FAIL stream_reads: got n=%0d cycles %0d..%0d expected 8 cycles 0..7", nrd, first_rd, last_rd);
        else n_pass++;
        n_checks++;
        if (nd != 8 || first_d != 2 || last_d != 9)
            $display("FAIL stream_out: got n=%0d cycles %0d..%0d expected 8 cycles 2..9", nd, first_d, last_d);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int nrd = 0, nd = 0, first_d = -1, last_d = -1;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(16'h00A0 + 16'(i));
        for (int c = 0; c < 8; c++) begin
            sample();
            if (fifo_read) nrd++;
            if (c >= 4) begin
                n_checks++;
                if (m_valid !== 1'b1 || m_data !== 16'h00A0)
                    $display("FAIL hold: got valid=%b data=%h expected 1/00a0", m_valid, m_data);
                else n_pass++;
            end
        end
        n_checks++;
        if (nrd != 2) $display("FAIL hold_reads: got %0d expected 2", nrd); else n_pass++;
        tick();
        m_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            sample();
            if (fifo_read) nrd++;
            if (m_valid && m_ready) begin
                n_checks++;
                if (m_data !== 16'h00A0 + 16'(nd)) $display("FAIL drain_data: got %h expected %h", m_data, 16'h00A0 + 16'(nd));
                else n_pass++;
                if (first_d < 0) first_d = c;
                last_d = c;
                nd++;
            end
        end
        n_checks++;
        if (nd != 5 || last_d - first_d != 4 || nrd != 5)
            $display("FAIL drain_gapless: got n=%0d span=%0d reads=%0d expected 5/4/5", nd, last_d - first_d, nrd);
        else n_pass++;
    endtask

    task automatic test_toggle();
        int nd = 0;
        tick();
        for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i));
        for (int c = 0; c < 100 && nd < 16; c++) begin
            m_ready = (c % 2 == 0);
            sample();
            if (m_valid && m_ready) begin
                n_checks++;
                if (m_data !== 16'h1000 + 16'(nd)) $display("FAIL toggle_data: got %h expected %h", m_data, 16'h1000 + 16'(nd));
                else n_pass++;
                nd++;
            end
            tick();
        end
        m_ready = 1'b1;
        n_checks++;
        if (nd != 16) $display("FAIL toggle_count: got %0d expected 16", nd); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int nd = 0;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(16'h00C0 + 16'(i));
        tick();
        tick();
        areset_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 16'h0000 || fifo_read !== 1'b0)
            $display("FAIL midrst_out: got valid=%b data=%h read=%b expected 0/0000/0", m_valid, m_data, fifo_read);
        else n_pass++;
        tick();
        tick();
        areset_n = 1'b1;
        m_ready  = 1'b1;
        sample();
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL midrst_nocap: got valid=%b expected 0", m_valid); else n_pass++;
        for (int c = 0; c < 20; c++) begin
            if (m_valid && m_ready) begin
                n_checks++;
                if (m_data !== 16'h00C2 + 16'(nd)) $display("FAIL midrst_data: got %h expected %h", m_data, 16'h00C2 + 16'(nd));
                else n_pass++;
                nd++;
            end
            sample();
        end
        n_checks++;
        if (nd != 4) $display("FAIL midrst_count: got %0d expected 4", nd); else n_pass++;
    endtask

`ifdef FIFO_DRAIN_CNT_EN
    task automatic test_counter();
        int nd = 0;
        tick();
        areset_n = 1'b0;
        exp_q.delete();
        tick();
        areset_n = 1'b1;
        for (int i = 0; i < 65537; i++) push(16'(i));
        for (int c = 0; c < 65600 && nd < 65537; c++) begin
            sample();
            if (m_valid && m_ready) nd++;
        end
        tick();
        n_checks++;
        if (nd != 65537 || sample_cnt !== 16'h0001)
            $display("FAIL cnt_wrap: got n=%0d cnt=%h expected 65537/0001", nd, sample_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_reset_midstream();
`ifdef FIFO_DRAIN_CNT_EN
        test_counter();
`endif
        repeat (4) tick();
        n_checks++;
        if (exp_q.size() != 0 || mem.size() != 0)
            $display("FAIL leftover: got sb=%0d fifo=%0d expected 0/0", exp_q.size(), mem.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
